// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package sipo_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sipo_out_reg.sv
// Output holding register for assembled words: valid/ready handshake and
// sticky overrun when a finished word cannot be accepted.
module sipo_out_reg import sipo_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             par_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] par_data,
  output logic             par_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;
  logic             ovr;
  logic             consume;
  logic             drop;

  assign consume = vld_p1 & par_ready;
  assign drop    = load & vld_p1 & ~par_ready;

  // ---- stage p1: holding register ----
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (load && !drop) begin
        data_p1 <= word;
        vld_p1  <= 1'b1;
      end else if (consume) begin
        vld_p1  <= 1'b0;
      end
      // A drop on the same edge as clr_err wins so the event is not lost.
      if (drop) begin
        ovr <= 1'b1;
      end else if (clr_err) begin
        ovr <= 1'b0;
      end
    end
  end

  assign par_data  = data_p1;
  assign par_valid = vld_p1;
  assign overrun   = ovr;

endmodule

// File: rtl/sipo_deser.sv
// Serial-to-parallel deserializer: frames on ser_sof, assembles WIDTH-bit
// words from a continuous qualified bit stream and hands them to sipo_out_reg.
module sipo_deser import sipo_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     ser_d,
  input  logic                     ser_en,
  input  logic                     ser_sof,
  output logic [WIDTH-1:0]         par_data,
  output logic                     par_valid,
  input  logic                     par_ready,
  input  logic                     clr_err,
  output logic                     overrun,
  output logic                     frame_err,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  ONE      = CW'(1);

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r,
                                                input logic             d);
    if (MSB_FIRST != 0) begin
      return {r[WIDTH-2:0], d};
    end else begin
      return {d, r[WIDTH-1:1]};
    end
  endfunction

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sreg_p0, sreg_nxt;
  logic [WIDTH-1:0] word;
  logic             word_done;
  logic             frame_set;
  logic             ferr;

  assign word = shift_in(sreg_p0, ser_d);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg_p0;
    word_done = 1'b0;
    frame_set = 1'b0;
    if (ser_en) begin
      unique case (state)
        IDLE: begin
          if (ser_sof) begin
            sreg_nxt  = shift_in('0, ser_d);
            cnt_nxt   = ONE;
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (ser_sof) begin
            // Restart at a word boundary is legal; mid-word it flags a framing error.
            frame_set = (cnt != '0);
            sreg_nxt  = shift_in('0, ser_d);
            cnt_nxt   = ONE;
          end else if (cnt == LAST_BIT) begin
            word_done = 1'b1;
            sreg_nxt  = '0;
            cnt_nxt   = '0;
          end else begin
            sreg_nxt  = word;
            cnt_nxt   = cnt + ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---- stage p0: shift register, bit counter, FSM ----
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state   <= IDLE;
      cnt     <= '0;
      sreg_p0 <= '0;
      ferr    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sreg_p0 <= sreg_nxt;
      if (frame_set) begin
        ferr <= 1'b1;
      end else if (clr_err) begin
        ferr <= 1'b0;
      end
    end
  end

  sipo_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst_l    (rst_l),
    .load     (word_done),
    .word     (word),
    .par_ready(par_ready),
    .clr_err  (clr_err),
    .par_data (par_data),
    .par_valid(par_valid),
    .overrun  (overrun)
  );

  assign bit_cnt   = cnt;
  assign frame_err = ferr;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: MSB-first and LSB-first instances share the
// stimulus; expected words are queued when the completing bit is driven.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       ser_d = 1'b0;
  logic       ser_en = 1'b0;
  logic       ser_sof = 1'b0;
  logic       par_ready = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, a_ovr, b_ovr, a_ferr, b_ferr;
  logic [2:0] a_cnt, b_cnt;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst_l(rst_l), .ser_d(ser_d), .ser_en(ser_en), .ser_sof(ser_sof),
    .par_data(a_data), .par_valid(a_valid), .par_ready(par_ready), .clr_err(clr_err),
    .overrun(a_ovr), .frame_err(a_ferr), .bit_cnt(a_cnt)
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_l(rst_l), .ser_d(ser_d), .ser_en(ser_en), .ser_sof(ser_sof),
    .par_data(b_data), .par_valid(b_valid), .par_ready(par_ready), .clr_err(clr_err),
    .overrun(b_ovr), .frame_err(b_ferr), .bit_cnt(b_cnt)
  );

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic d, input logic sof);
    ser_d   = d;
    ser_en  = 1'b1;
    ser_sof = sof;
    tick();
    ser_en  = 1'b0;
    ser_sof = 1'b0;
  endtask

  // Bits go out w[7] first; the MSB-first instance rebuilds w, the other rev8(w).
  task automatic send_word(input logic [7:0] w, input logic sof, input logic push);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && push) begin
        qa.push_back(w);
        qb.push_back(rev8(w));
      end
      send_bit(w[7-i], sof && (i == 0));
    end
  endtask

  task automatic expect_word(input string tag);
    logic [7:0] ea, eb;
    if (qa.size() == 0 || qb.size() == 0) begin
      chk({tag, "_queue"}, 32'(qa.size()), 32'd1);
    end else begin
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk({tag, "_valid_msb"}, 32'(a_valid), 32'd1);
      chk({tag, "_data_msb"}, 32'(a_data), 32'(ea));
      chk({tag, "_valid_lsb"}, 32'(b_valid), 32'd1);
      chk({tag, "_data_lsb"}, 32'(b_data), 32'(eb));
    end
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_data", 32'(a_data), 32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_flags", 32'({a_ovr, a_ferr, b_ovr, b_ferr}), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    tick();

    // Single word 0x96, consumer always ready
    par_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    chk("first_cnt", 32'(a_cnt), 32'd1);
    for (int i = 1; i < 8; i++) begin
      if (i == 7) begin
        qa.push_back(8'h96);
        qb.push_back(rev8(8'h96));
      end
      send_bit(((8'h96 >> (7 - i)) & 8'h01) != 0, 1'b0);
    end
    expect_word("w96");
    chk("w96_lsb_is_69", 32'(b_data), 32'h69);
    chk("w96_cnt_wrap", 32'(a_cnt), 32'd0);
    tick();
    chk("w96_valid_one_cycle", 32'(a_valid), 32'd0);

    // Back-to-back words with consumer stalled: second word is dropped
    par_ready = 1'b0;
    send_word(8'h96, 1'b1, 1'b1);
    chk("boundary_sof_no_ferr", 32'(a_ferr), 32'd0);
    send_word(8'h3C, 1'b0, 1'b0);
    chk("ovr_set", 32'(a_ovr), 32'd1);
    chk("ovr_set_lsb", 32'(b_ovr), 32'd1);
    expect_word("ovr_keep");
    repeat (3) tick();
    chk("ovr_hold_data", 32'(a_data), 32'h96);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovr_cleared", 32'(a_ovr), 32'd0);
    chk("ovr_valid_kept", 32'(a_valid), 32'd1);
    par_ready = 1'b1;
    tick();
    par_ready = 1'b0;
    chk("ovr_drained", 32'(a_valid), 32'd0);

    // Completion and consumption on the same edge
    send_word(8'h96, 1'b0, 1'b1);
    expect_word("sim_first");
    for (int i = 0; i < 7; i++) send_bit(((8'h3C >> (7 - i)) & 8'h01) != 0, 1'b0);
    par_ready = 1'b1;
    qa.push_back(8'h3C);
    qb.push_back(rev8(8'h3C));
    send_bit(1'b0, 1'b0);
    expect_word("sim_second");
    chk("sim_no_ovr", 32'(a_ovr), 32'd0);
    tick();
    chk("sim_drained", 32'(a_valid), 32'd0);

    // Mid-word sof: framing error, then a full 0xFF word
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("pre_ferr", 32'(a_ferr), 32'd0);
    chk("pre_ferr_cnt", 32'(a_cnt), 32'd3);
    send_bit(1'b1, 1'b1);
    chk("ferr_set", 32'(a_ferr), 32'd1);
    chk("ferr_set_lsb", 32'(b_ferr), 32'd1);
    chk("ferr_restart_cnt", 32'(a_cnt), 32'd1);
    qa.push_back(8'hFF);
    qb.push_back(8'hFF);
    for (int i = 1; i < 8; i++) send_bit(1'b1, 1'b0);
    expect_word("ferr_word");
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ferr_cleared", 32'(a_ferr), 32'd0);

    // Asynchronous reset mid-word with a word pending
    par_ready = 1'b0;
    send_word(8'h5A, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    chk("prereset_cnt", 32'(a_cnt), 32'd5);
    chk("prereset_valid", 32'(a_valid), 32'd1);
    #2;
    rst_l = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    chk("arst_data", 32'({a_data, b_data}), 32'd0);
    chk("arst_valid", 32'({a_valid, b_valid}), 32'd0);
    chk("arst_cnt", 32'(a_cnt), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    send_word(8'hA5, 1'b0, 1'b0);
    chk("nosof_valid", 32'(a_valid), 32'd0);
    chk("nosof_cnt", 32'(a_cnt), 32'd0);
    par_ready = 1'b1;
    send_word(8'hC3, 1'b1, 1'b1);
    expect_word("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
